// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light sensor path: light encodings,
// debounce state encoding and the debounce counter width.
package traffic_pkg;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    DB_IDLE    = 2'b00,
    DB_QUALIFY = 2'b01,
    DB_PRESENT = 2'b10,
    DB_RELEASE = 2'b11
  } db_state_e;

  // Only an exact green code counts as service; illegal codes do not.
  function automatic logic is_green(input logic [2:0] light);
    return light == LIGHT_GREEN;
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// One detector channel: two-flop synchronizer followed by a symmetric
// debounce FSM. present_next_o exposes the next-state level so the call
// memory in the top can update on the same edge as present_o.
//
// state   | meaning
// --------+------------------------------------------------------
// IDLE    | no vehicle, waiting for a synchronized high sample
// QUALIFY | high seen, counting consecutive high samples
// PRESENT | vehicle accepted, waiting for a low sample
// RELEASE | low seen, counting consecutive low samples
module sensor_debounce
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic present_o,
  output logic present_next_o
);

  localparam logic [CNT_W-1:0] TC = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s2_q;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             present_q, present_d;

  // Bring the asynchronous detector into clk domain.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= raw_i;
      s2_q <= s1_q;
    end
  end

  // Next-state and counter logic; a count of 1 skips the counting states.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      DB_IDLE: begin
        if (s2_q) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = DB_PRESENT;
            cnt_d   = '0;
          end else begin
            state_d = DB_QUALIFY;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      DB_QUALIFY: begin
        if (!s2_q) begin
          state_d = DB_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == TC) begin
          state_d = DB_PRESENT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DB_PRESENT: begin
        if (!s2_q) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = DB_IDLE;
            cnt_d   = '0;
          end else begin
            state_d = DB_RELEASE;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      DB_RELEASE: begin
        if (s2_q) begin
          state_d = DB_PRESENT;
          cnt_d   = '0;
        end else if (cnt_q == TC) begin
          state_d = DB_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = DB_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign present_d = (state_d == DB_PRESENT) || (state_d == DB_RELEASE);

  // Debounce state, counter and the registered present level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= DB_IDLE;
      cnt_q     <= '0;
      present_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      present_q <= present_d;
    end
  end

  assign present_o      = present_q;
  assign present_next_o = present_d;

endmodule

// File: rtl/vehicle_sensor_conditioner.sv
// Conditions the raw NS/EW loop detectors into the controller's sensor
// inputs. Build option SENSOR_LATCH_EN adds per-approach call memory that
// holds demand until that approach shows green; without it the sensor
// outputs are the debounced levels and the light inputs are ignored.
module vehicle_sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       NS_raw,
  input  logic       EW_raw,
  input  logic [2:0] NS_light,
  input  logic [2:0] EW_light,
  output logic       NS_sensor,
  output logic       EW_sensor,
  output logic       NS_present,
  output logic       EW_present
);

  logic ns_present_next;
  logic ew_present_next;

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ns_debounce (
    .clk_i          (clk),
    .rst_i          (rst),
    .raw_i          (NS_raw),
    .present_o      (NS_present),
    .present_next_o (ns_present_next)
  );

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ew_debounce (
    .clk_i          (clk),
    .rst_i          (rst),
    .raw_i          (EW_raw),
    .present_o      (EW_present),
    .present_next_o (ew_present_next)
  );

`ifdef SENSOR_LATCH_EN
  logic ns_latch_q, ns_latch_d;
  logic ew_latch_q, ew_latch_d;

  // A present vehicle sets the call; only own green clears it, set wins.
  always_comb begin
    ns_latch_d = ns_present_next ? 1'b1 : (is_green(NS_light) ? 1'b0 : ns_latch_q);
    ew_latch_d = ew_present_next ? 1'b1 : (is_green(EW_light) ? 1'b0 : ew_latch_q);
  end

  // Call memory registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ns_latch_q <= 1'b0;
      ew_latch_q <= 1'b0;
    end else begin
      ns_latch_q <= ns_latch_d;
      ew_latch_q <= ew_latch_d;
    end
  end

  assign NS_sensor = ns_latch_q;
  assign EW_sensor = ew_latch_q;
`else
  logic unused_call_memory_inputs;
  assign unused_call_memory_inputs = ^{NS_light, EW_light, ns_present_next, ew_present_next};

  assign NS_sensor = NS_present;
  assign EW_sensor = EW_present;
`endif

endmodule

// File: tb/tb_vehicle_sensor_conditioner.sv
// Directed bench: each stimulus cycle pushes the outputs expected after the
// next clock edge; a monitor pops and compares shortly after every edge.
module tb_vehicle_sensor_conditioner;
  import traffic_pkg::*;

`ifdef SENSOR_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       ns_raw, ew_raw, ns1_raw;
  logic [2:0] ns_light, ew_light;
  logic       ns_sensor, ew_sensor, ns_present, ew_present;
  logic       n1_sensor, e1_sensor, n1_present, e1_present;

  vehicle_sensor_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .NS_raw     (ns_raw),
    .EW_raw     (ew_raw),
    .NS_light   (ns_light),
    .EW_light   (ew_light),
    .NS_sensor  (ns_sensor),
    .EW_sensor  (ew_sensor),
    .NS_present (ns_present),
    .EW_present (ew_present)
  );

  vehicle_sensor_conditioner #(.DEBOUNCE_CYCLES(1)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .NS_raw     (ns1_raw),
    .EW_raw     (1'b0),
    .NS_light   (ns_light),
    .EW_light   (ew_light),
    .NS_sensor  (n1_sensor),
    .EW_sensor  (e1_sensor),
    .NS_present (n1_present),
    .EW_present (e1_present)
  );

  typedef struct packed {
    logic nsp;
    logic nss;
    logic ewp;
    logic ews;
    logic n1p;
    logic n1s;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  exp_t m;
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0b required=%0b at t=%0t", name, act, req, $time);
    end
  endtask

  // Queue the expectation for the coming edge, then move to the next negedge.
  task automatic cyc();
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
        m = exp_q.pop_front();
        chk("ns_present", ns_present, m.nsp);
        chk("ns_sensor",  ns_sensor,  m.nss);
        chk("ew_present", ew_present, m.ewp);
        chk("ew_sensor",  ew_sensor,  m.ews);
        chk("d1_ns_present", n1_present, m.n1p);
        chk("d1_ns_sensor",  n1_sensor,  m.n1s);
        chk("d1_ew_present", e1_present, 1'b0);
        chk("d1_ew_sensor",  e1_sensor,  1'b0);
      end
    end
  end

  initial begin
    bit pat [8];
    pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    rst      = 1'b1;
    ns_raw   = 1'b0;
    ew_raw   = 1'b0;
    ns1_raw  = 1'b0;
    ns_light = LIGHT_RED;
    ew_light = LIGHT_RED;
    e        = '0;

    // Reset held, then first cycle after release.
    cyc();
    cyc();
    rst = 1'b0;
    cyc();

    // Clean NS rising and falling edges; call memory holds until green.
    ns_raw = 1'b1;
    for (int k = 0; k < 8; k++) begin
      e.nsp = (k >= 5);
      e.nss = (k >= 5);
      cyc();
    end
    ns_raw = 1'b0;
    for (int k = 0; k < 8; k++) begin
      e.nsp = (k < 5);
      e.nss = LATCH || (k < 5);
      cyc();
    end
    ns_light = LIGHT_GREEN;
    e.nss = 1'b0;
    cyc();
    cyc();
    ns_light = LIGHT_RED;

    // EW bounce 3 high / 1 low / 3 high / 1 low is rejected.
    for (int i = 0; i < 8; i++) begin
      ew_raw = pat[i];
      cyc();
    end
    // Then held high for 10 cycles.
    ew_raw = 1'b1;
    for (int k = 0; k < 10; k++) begin
      e.ewp = (k >= 5);
      e.ews = (k >= 5);
      cyc();
    end
    ew_raw = 1'b0;
    for (int k = 0; k < 8; k++) begin
      e.ewp = (k < 5);
      e.ews = LATCH || (k < 5);
      cyc();
    end
    // Yellow and an illegal code never clear the call.
    ew_light = LIGHT_YELLOW;
    e.ews = LATCH;
    repeat (3) cyc();
    ew_light = 3'b111;
    repeat (3) cyc();
    ew_light = LIGHT_GREEN;
    e.ews = 1'b0;
    cyc();
    cyc();
    ew_light = LIGHT_RED;
    cyc();

    // Set beats clear: NS present during its own green keeps demand.
    ns_light = LIGHT_GREEN;
    ns_raw = 1'b1;
    for (int k = 0; k < 10; k++) begin
      e.nsp = (k >= 5);
      e.nss = (k >= 5);
      cyc();
    end
    ns_raw = 1'b0;
    for (int k = 0; k < 8; k++) begin
      e.nsp = (k < 5);
      e.nss = (k < 5);
      cyc();
    end
    ns_light = LIGHT_RED;

    // Simultaneous events on both channels.
    ns_raw = 1'b1;
    ew_raw = 1'b1;
    for (int k = 0; k < 8; k++) begin
      e.nsp = (k >= 5);
      e.nss = (k >= 5);
      e.ewp = (k >= 5);
      e.ews = (k >= 5);
      cyc();
    end
    ns_raw = 1'b0;
    ew_raw = 1'b0;
    for (int k = 0; k < 8; k++) begin
      e.nsp = (k < 5);
      e.nss = LATCH || (k < 5);
      e.ewp = (k < 5);
      e.ews = LATCH || (k < 5);
      cyc();
    end
    ns_light = LIGHT_GREEN;
    ew_light = LIGHT_GREEN;
    e.nss = 1'b0;
    e.ews = 1'b0;
    cyc();
    ns_light = LIGHT_RED;
    ew_light = LIGHT_RED;
    cyc();

    // Reset asserted mid-PRESENT clears everything asynchronously.
    ns_raw = 1'b1;
    for (int k = 0; k < 8; k++) begin
      e.nsp = (k >= 5);
      e.nss = (k >= 5);
      cyc();
    end
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_ns_present", ns_present, 1'b0);
    chk("async_rst_ns_sensor",  ns_sensor,  1'b0);
    chk("async_rst_ew_present", ew_present, 1'b0);
    chk("async_rst_ew_sensor",  ew_sensor,  1'b0);
    e = '0;
    @(negedge clk);
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      e.nsp = (k >= 5);
      e.nss = (k >= 5);
      cyc();
    end
    ns_raw = 1'b0;
    for (int k = 0; k < 8; k++) begin
      e.nsp = (k < 5);
      e.nss = LATCH || (k < 5);
      cyc();
    end
    ns_light = LIGHT_GREEN;
    e.nss = 1'b0;
    cyc();

    // DEBOUNCE_CYCLES=1 instance, NS light green so sensor follows present.
    ns1_raw = 1'b1;
    for (int k = 0; k < 4; k++) begin
      e.n1p = (k >= 2);
      e.n1s = (k >= 2);
      cyc();
    end
    ns1_raw = 1'b0;
    for (int k = 0; k < 4; k++) begin
      e.n1p = (k < 2);
      e.n1s = (k < 2);
      cyc();
    end
    // A single synchronized sample is accepted at this setting.
    for (int k = 0; k < 5; k++) begin
      ns1_raw = (k == 0);
      e.n1p = (k == 2);
      e.n1s = (k == 2);
      cyc();
    end
    ns_light = LIGHT_RED;
    cyc();

    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", exp_q.size() == 0, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
